hdlc_rx_controller: RTL and testbench

- Sequences the HDLC receive path: tracks frame start/end reported by the RX channel, writes deframed bytes into the RX buffer, and applies the FCS, abort, overflow and short-frame rules.
- Presents a completed frame (Ready, FrameSize) to the host register interface.
- Companion to the TX controller; sits between the RX channel/FCS checker and the RX buffer.

---
 rtl/hdlc_rx_pkg.sv | 24 ++
 rtl/hdlc_rx_byte_counter.sv | 46 ++++
 rtl/hdlc_rx_controller.sv | 172 +++++++++++++++++
 tb/tb_hdlc_rx_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_rx_pkg.sv
// Shared types and constants for the HDLC receive controller.
//   rx_state_e        : controller state encoding
//   FCS_BYTES_DEFAULT : number of trailing FCS bytes in a frame
//   MIN_FRAME_BYTES   : shortest frame accepted with the default FCS length
//   min_frame_bytes() : shortest acceptable frame for a given FCS length
//                       (FCS plus at least one payload byte)
package hdlc_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_CHECK,
    ST_READY,
    ST_DISCARD
  } rx_state_e;

  localparam int FCS_BYTES_DEFAULT = 2;
  localparam int MIN_FRAME_BYTES   = FCS_BYTES_DEFAULT + 1;

  function automatic int min_frame_bytes(input int fcs_bytes);
    return fcs_bytes + 1;
  endfunction

endpackage

// File: rtl/hdlc_rx_byte_counter.sv
// Byte counter for the receive path. It saturates at MAX_BYTES so the count
// can never run past the buffer depth.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_i      : clear to zero (takes priority over inc_i)
//   inc_i      : count one byte (ignored once at max)
//   count_o    : current byte count
//   at_max_o   : count has reached MAX_BYTES
module hdlc_rx_byte_counter #(
  parameter int MAX_BYTES = 128,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_CNT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MAX_CNT);

endmodule

// File: rtl/hdlc_rx_controller.sv
// HDLC receive controller: follows frame start/end from the RX channel,
// writes deframed bytes into the RX buffer, applies abort / drop / overflow /
// FCS / short-frame rules and presents a finished frame to the host.
// Ports:
//   Clk, Rst            : clock (rising edge), asynchronous active-low reset
//   RxEN, FCSEn         : host configuration
//   ValidFrame          : channel is between opening and closing flag
//   NewByte             : a deframed byte is on the buffer data input
//   AbortDetect         : abort pattern seen on the line
//   FCSErr              : FCS checker verdict, sampled in CHECK
//   Drop, ReadDone      : host discards / has finished with the held frame
//   StartFCS            : pulse restarting the FCS checker
//   WrBuff, BuffAddr    : RX buffer write strobe and address
//   Ready, FrameSize    : a frame is held, and its payload length
//   EndOfFrame          : pulse, frame accepted
//   FrameError/Overflow : sticky status of the last frame
//   AbortSignal         : pulse, frame aborted
module hdlc_rx_controller
  import hdlc_rx_pkg::*;
#(
  parameter int  MAX_BYTES = 128,
  parameter int  FCS_BYTES = FCS_BYTES_DEFAULT,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             RxEN,
  input  logic             FCSEn,
  input  logic             ValidFrame,
  input  logic             NewByte,
  input  logic             AbortDetect,
  input  logic             FCSErr,
  input  logic             Drop,
  input  logic             ReadDone,
  output logic             StartFCS,
  output logic             WrBuff,
  output logic [CNT_W-1:0] BuffAddr,
  output logic             Ready,
  output logic [CNT_W-1:0] FrameSize,
  output logic             EndOfFrame,
  output logic             FrameError,
  output logic             Overflow,
  output logic             AbortSignal
);

  localparam logic [CNT_W-1:0] FCS_CNT = CNT_W'(FCS_BYTES);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(min_frame_bytes(FCS_BYTES));

  rx_state_e        state_q;
  logic             start_fcs_q;
  logic             wr_q;
  logic [CNT_W-1:0] addr_q;
  logic             ready_q;
  logic [CNT_W-1:0] size_q;
  logic             eof_q;
  logic             frame_err_q;
  logic             overflow_q;
  logic             abort_q;

  logic [CNT_W-1:0] byte_count;
  logic             byte_at_max;
  logic             frame_start;
  logic             byte_accept;

  assign frame_start = (state_q == ST_IDLE) && RxEN && ValidFrame;
  // Same precedence as the RECEIVE branch of the FSM: a byte only counts if
  // no disable, abort or drop wins in that cycle and there is room for it.
  assign byte_accept = (state_q == ST_RECEIVE) && RxEN && !AbortDetect && !Drop &&
                       NewByte && !byte_at_max;

  hdlc_rx_byte_counter #(
    .MAX_BYTES(MAX_BYTES),
    .CNT_W    (CNT_W)
  ) u_byte_counter (
    .clk     (Clk),
    .rst_n   (Rst),
    .clr_i   (frame_start),
    .inc_i   (byte_accept),
    .count_o (byte_count),
    .at_max_o(byte_at_max)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      start_fcs_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      size_q      <= '0;
      eof_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      start_fcs_q <= 1'b0;
      wr_q        <= 1'b0;
      eof_q       <= 1'b0;
      abort_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q     <= ST_RECEIVE;
            start_fcs_q <= 1'b1;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        ST_RECEIVE: begin
          if (!RxEN) begin
            state_q <= ST_IDLE;
          end else if (AbortDetect) begin
            abort_q <= 1'b1;
            state_q <= ST_DISCARD;
          end else if (Drop) begin
            state_q <= ST_DISCARD;
          end else if (NewByte && byte_at_max) begin
            overflow_q <= 1'b1;
            state_q    <= ST_DISCARD;
          end else begin
            // A byte arriving together with the end of frame still counts.
            if (NewByte) begin
              wr_q   <= 1'b1;
              addr_q <= byte_count;
            end
            if (!ValidFrame) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!RxEN) begin
            state_q <= ST_IDLE;
          end else if ((FCSEn && FCSErr) || (byte_count < MIN_CNT)) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            ready_q <= 1'b1;
            eof_q   <= 1'b1;
            size_q  <= FCSEn ? (byte_count - FCS_CNT) : byte_count;
            state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (ReadDone || Drop) begin
            ready_q <= 1'b0;
            size_q  <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (!RxEN || !ValidFrame) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign StartFCS    = start_fcs_q;
  assign WrBuff      = wr_q;
  assign BuffAddr    = addr_q;
  assign Ready       = ready_q;
  assign FrameSize   = size_q;
  assign EndOfFrame  = eof_q;
  assign FrameError  = frame_err_q;
  assign Overflow    = overflow_q;
  assign AbortSignal = abort_q;

endmodule

// File: tb/tb_hdlc_rx_controller.sv
// Directed bench for hdlc_rx_controller. Expected write addresses go into a
// scoreboard queue as bytes are driven; a monitor pops them when WrBuff fires.
module tb_hdlc_rx_controller;

  localparam int CNT_W = 8;

  logic             Clk;
  logic             Rst;
  logic             RxEN;
  logic             FCSEn;
  logic             ValidFrame;
  logic             NewByte;
  logic             AbortDetect;
  logic             FCSErr;
  logic             Drop;
  logic             ReadDone;
  logic             StartFCS;
  logic             WrBuff;
  logic [CNT_W-1:0] BuffAddr;
  logic             Ready;
  logic [CNT_W-1:0] FrameSize;
  logic             EndOfFrame;
  logic             FrameError;
  logic             Overflow;
  logic             AbortSignal;

  int tests;
  int fails;
  int wr_count;
  int exp_q[$];
  int mon_exp;

  hdlc_rx_controller #(.MAX_BYTES(128), .FCS_BYTES(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .RxEN       (RxEN),
    .FCSEn      (FCSEn),
    .ValidFrame (ValidFrame),
    .NewByte    (NewByte),
    .AbortDetect(AbortDetect),
    .FCSErr     (FCSErr),
    .Drop       (Drop),
    .ReadDone   (ReadDone),
    .StartFCS   (StartFCS),
    .WrBuff     (WrBuff),
    .BuffAddr   (BuffAddr),
    .Ready      (Ready),
    .FrameSize  (FrameSize),
    .EndOfFrame (EndOfFrame),
    .FrameError (FrameError),
    .Overflow   (Overflow),
    .AbortSignal(AbortSignal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_startfcs"}, StartFCS, 0);
    check({tag, "_wrbuff"}, WrBuff, 0);
    check({tag, "_buffaddr"}, BuffAddr, 0);
    check({tag, "_ready"}, Ready, 0);
    check({tag, "_framesize"}, FrameSize, 0);
    check({tag, "_eof"}, EndOfFrame, 0);
    check({tag, "_frameerror"}, FrameError, 0);
    check({tag, "_overflow"}, Overflow, 0);
    check({tag, "_abort"}, AbortSignal, 0);
  endtask

  // Raise ValidFrame and check whether the controller restarts the FCS.
  task automatic start_frame(input logic exp_start);
    ValidFrame = 1'b1;
    wr_count = 0;
    tick();
    check("start_fcs", StartFCS, exp_start);
  endtask

  // One NewByte pulse every other cycle; expected addresses are queued.
  task automatic send_bytes(input int n, input bit expect_wr, input int base);
    for (int i = 0; i < n; i++) begin
      NewByte = 1'b1;
      if (expect_wr) exp_q.push_back(base + i);
      tick();
      NewByte = 1'b0;
      tick();
    end
  endtask

  // Close the frame; after return the CHECK outcome is visible.
  task automatic end_frame(input logic fcs_err);
    ValidFrame = 1'b0;
    FCSErr = fcs_err;
    tick();
    check("check_no_ready_yet", Ready, 0);
    tick();
    FCSErr = 1'b0;
  endtask

  task automatic read_done();
    ReadDone = 1'b1;
    tick();
    ReadDone = 1'b0;
    check("readdone_ready", Ready, 0);
    check("readdone_size", FrameSize, 0);
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge Clk) begin
    if (WrBuff) begin
      wr_count++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("wr_addr", BuffAddr, mon_exp);
        $display("[TB] write addr %0d (expected %0d)", BuffAddr, mon_exp);
      end else begin
        check("unexpected_wr", WrBuff, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout observed 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0; wr_count = 0;
    Rst = 1'b1; RxEN = 1'b0; FCSEn = 1'b0; ValidFrame = 1'b0; NewByte = 1'b0;
    AbortDetect = 1'b0; FCSErr = 1'b0; Drop = 1'b0; ReadDone = 1'b0;
    #1 Rst = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    Rst = 1'b1;
    tick();
    RxEN = 1'b1;
    FCSEn = 1'b1;

    // Good frame with FCS: 10 bytes -> payload 8.
    start_frame(1'b1);
    send_bytes(10, 1'b1, 0);
    end_frame(1'b0);
    check("good_ready", Ready, 1);
    check("good_eof", EndOfFrame, 1);
    check("good_size", FrameSize, 8);
    check("good_frameerror", FrameError, 0);
    check("good_wr_count", wr_count, 10);
    tick();
    check("good_eof_pulse", EndOfFrame, 0);
    check("good_ready_hold", Ready, 1);
    read_done();
    $display("[TB] good frame done");

    // FCS error with checking enabled.
    start_frame(1'b1);
    send_bytes(10, 1'b1, 0);
    end_frame(1'b1);
    check("badfcs_err", FrameError, 1);
    check("badfcs_ready", Ready, 0);
    check("badfcs_eof", EndOfFrame, 0);
    $display("[TB] bad FCS frame done");

    // Same error with checking disabled: frame accepted at full length.
    FCSEn = 1'b0;
    start_frame(1'b1);
    check("err_clear_on_start", FrameError, 0);
    send_bytes(10, 1'b1, 0);
    end_frame(1'b1);
    check("nofcs_ready", Ready, 1);
    check("nofcs_size", FrameSize, 10);
    check("nofcs_frameerror", FrameError, 0);
    read_done();
    FCSEn = 1'b1;
    $display("[TB] FCS disabled frame done");

    // Abort together with a 5th byte.
    start_frame(1'b1);
    send_bytes(4, 1'b1, 0);
    NewByte = 1'b1;
    AbortDetect = 1'b1;
    tick();
    NewByte = 1'b0;
    AbortDetect = 1'b0;
    check("abort_pulse", AbortSignal, 1);
    tick();
    check("abort_pulse_end", AbortSignal, 0);
    AbortDetect = 1'b1;
    tick();
    AbortDetect = 1'b0;
    tick();
    check("abort_second_ignored", AbortSignal, 0);
    ValidFrame = 1'b0;
    repeat (2) tick();
    check("abort_wr_count", wr_count, 4);
    check("abort_ready", Ready, 0);
    start_frame(1'b1);
    send_bytes(5, 1'b1, 0);
    end_frame(1'b0);
    check("post_abort_ready", Ready, 1);
    check("post_abort_size", FrameSize, 3);
    read_done();
    $display("[TB] abort frame done");

    // Overflow: 129 bytes, only 128 written.
    start_frame(1'b1);
    send_bytes(128, 1'b1, 0);
    send_bytes(1, 1'b0, 0);
    check("ovf_flag", Overflow, 1);
    ValidFrame = 1'b0;
    repeat (2) tick();
    check("ovf_wr_count", wr_count, 128);
    check("ovf_ready", Ready, 0);
    check("ovf_sticky", Overflow, 1);
    $display("[TB] overflow frame done");

    // Next frame start clears Overflow; this one is too short (2 bytes).
    start_frame(1'b1);
    check("ovf_clear_on_start", Overflow, 0);
    send_bytes(2, 1'b1, 0);
    end_frame(1'b0);
    check("short_err", FrameError, 1);
    check("short_ready", Ready, 0);
    $display("[TB] short frame done");

    // Hold a frame, then offer a second frame while READY.
    start_frame(1'b1);
    send_bytes(6, 1'b1, 0);
    end_frame(1'b0);
    check("hold_ready", Ready, 1);
    check("hold_size", FrameSize, 4);
    start_frame(1'b0);
    send_bytes(3, 1'b0, 0);
    ValidFrame = 1'b0;
    tick();
    check("ready_ignore_wr", wr_count, 0);
    check("ready_ignore_size", FrameSize, 4);
    check("ready_ignore_ready", Ready, 1);
    Drop = 1'b1;
    tick();
    Drop = 1'b0;
    check("drop_ready", Ready, 0);
    check("drop_size", FrameSize, 0);
    $display("[TB] frame while ready done");

    // Asynchronous reset mid-receive, while a write strobe is high.
    start_frame(1'b1);
    send_bytes(2, 1'b1, 0);
    NewByte = 1'b1;
    exp_q.push_back(2);
    tick();
    NewByte = 1'b0;
    #2 Rst = 1'b0;
    #1 check_all_zero("async_reset");
    ValidFrame = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    start_frame(1'b1);
    send_bytes(4, 1'b1, 0);
    end_frame(1'b0);
    check("post_reset_ready", Ready, 1);
    check("post_reset_size", FrameSize, 2);
    check("post_reset_wr_count", wr_count, 4);
    read_done();
    $display("[TB] reset recovery done");

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
